// File: rtl/xil_prim_pkg.sv
// xil_prim_pkg: shared constants and helpers for carry-chain primitive models.
package xil_prim_pkg;
   localparam int SLICE_W = 4;
   function automatic int n_slices(input int width);
      return width / SLICE_W;
   endfunction
   function automatic bit width_ok(input int width);
      return width >= SLICE_W && width % SLICE_W == 0;
   endfunction
endpackage

// File: rtl/carry4_accum_carry4.sv
// carry4_accum_carry4: bit-exact CARRY4 model (mux select S ? carry : DI, O = S ^ carry-in).
module carry4_accum_carry4 (
   input  logic       CI,
   input  logic       CYINIT,
   input  logic [3:0] DI,
   input  logic [3:0] S,
   output logic [3:0] O,
   output logic [3:0] CO
);
   logic [4:0] c;
   always_comb begin
      c[0] = CI | CYINIT;
      for (int i = 0; i < 4; i++) c[i+1] = S[i] ? c[i] : DI[i];
   end
   assign O  = S ^ c[3:0];
   assign CO = c[4:1];
endmodule

// File: rtl/carry4_accum.sv
// carry4_accum: registered add/subtract accumulator on a cascade of CARRY4 slices.
module carry4_accum
   import xil_prim_pkg::*;
#(
   parameter int               WIDTH = 16,
   parameter logic [WIDTH-1:0] INIT  = '0
) (
   input  logic             C,
   input  logic             CLR,
   input  logic             CE,
   input  logic             LOAD,
   input  logic             SUB,
   input  logic [WIDTH-1:0] D,
   output logic [WIDTH-1:0] Q,
   output logic             COUT,
   output logic             OVF
);
   localparam int NS = n_slices(WIDTH);
   if (!width_ok(WIDTH)) begin : g_bad_width
      $error("carry4_accum: WIDTH %0d must be a multiple of %0d and at least %0d", WIDTH, SLICE_W, SLICE_W);
   end
   logic [WIDTH-1:0] dx, s, sum, co, q_q, q_d;
   logic [NS:0]      cc;
   logic             cout, cmsb, cout_q, cout_d, ovf_q, ovf_d, unused_co;
   assign dx    = SUB ? ~D : D;
   assign s     = q_q ^ dx;
   assign cc[0] = 1'b0;
   // Subtraction is Q + ~D + 1, the +1 entering through CYINIT of slice 0.
   for (genvar k = 0; k < NS; k++) begin : g_slice
      carry4_accum_carry4 u_carry4 (
         .CI    (cc[k]),
         .CYINIT(k == 0 ? SUB : 1'b0),
         .DI    (q_q[4*k +: 4]),
         .S     (s[4*k +: 4]),
         .O     (sum[4*k +: 4]),
         .CO    (co[4*k +: 4])
      );
      assign cc[k+1] = co[4*k+3];
   end
   assign cout      = cc[NS];
   assign cmsb      = co[WIDTH-2];
   assign unused_co = ^co;
   always_comb begin
      q_d    = !CE ? q_q    : LOAD ? D    : sum;
      cout_d = !CE ? cout_q : LOAD ? 1'b0 : cout;
      ovf_d  = !CE ? ovf_q  : LOAD ? 1'b0 : ovf_q | (cout ^ cmsb);
   end
   always_ff @(posedge C or posedge CLR) begin
      if (CLR) begin
         q_q    <= INIT;
         cout_q <= 1'b0;
         ovf_q  <= 1'b0;
      end else begin
         q_q    <= q_d;
         cout_q <= cout_d;
         ovf_q  <= ovf_d;
      end
   end
   assign Q    = q_q;
   assign COUT = cout_q;
   assign OVF  = ovf_q;
endmodule

// File: tb/tb_carry4_accum.sv
// tb_carry4_accum: directed and reference-model checks for the carry-chain accumulator.
module tb_carry4_accum;
   logic        C, CLR, CE, LOAD, SUB;
   logic [7:0]  d8, q8, q8i;
   logic [15:0] d16, q16;
   logic        c8, o8, c8i, o8i, c16, o16;
   logic [15:0] m_q;
   logic        m_c, m_o;
   int          checks, errors;

   carry4_accum #(.WIDTH(8)) u_w8 (
      .C(C), .CLR(CLR), .CE(CE), .LOAD(LOAD), .SUB(SUB), .D(d8), .Q(q8), .COUT(c8), .OVF(o8));
   carry4_accum #(.WIDTH(8), .INIT(8'h3C)) u_w8i (
      .C(C), .CLR(CLR), .CE(CE), .LOAD(LOAD), .SUB(SUB), .D(d8), .Q(q8i), .COUT(c8i), .OVF(o8i));
   carry4_accum #(.WIDTH(16)) u_w16 (
      .C(C), .CLR(CLR), .CE(CE), .LOAD(LOAD), .SUB(SUB), .D(d16), .Q(q16), .COUT(c16), .OVF(o16));

   initial C = 1'b0;
   always #5 C = ~C;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   task automatic model(input logic ce, input logic load, input logic sub, input logic [15:0] d);
      logic [16:0] r;
      if (!ce) return;
      if (load) begin
         m_q = d; m_c = 1'b0; m_o = 1'b0;
      end else begin
         r   = sub ? {1'b0, m_q} + {1'b0, ~d} + 17'd1 : {1'b0, m_q} + {1'b0, d};
         m_o = m_o | (sub ? (m_q[15] != d[15]) && (r[15] != m_q[15])
                          : (m_q[15] == d[15]) && (r[15] != m_q[15]));
         m_q = r[15:0];
         m_c = r[16];
      end
   endtask

   task automatic cyc(input logic ce, input logic load, input logic sub, input logic [15:0] d);
      @(negedge C);
      CE = ce; LOAD = load; SUB = sub; d8 = d[7:0]; d16 = d;
      model(ce, load, sub, d);
      @(posedge C);
      #1;
      check("q16_model", q16, m_q);
      check("cout16_model", c16, m_c);
      check("ovf16_model", o16, m_o);
   endtask

   task automatic chk8(input string tag, input logic [7:0] q, input logic c, input logic o);
      check({tag, "_q"}, q8, q);
      check({tag, "_cout"}, c8, c);
      check({tag, "_ovf"}, o8, o);
   endtask

   initial begin
      checks = 0; errors = 0;
      m_q = '0; m_c = 1'b0; m_o = 1'b0;
      CLR = 1'b1; CE = 1'b0; LOAD = 1'b0; SUB = 1'b0; d8 = '0; d16 = '0;
      #12 CLR = 1'b0;
      #1;
      chk8("reset", 8'h00, 1'b0, 1'b0);
      check("reset_init_q", q8i, 8'h3C);
      check("reset_q16", q16, 16'h0000);
      cyc(1, 1, 0, 16'h007F);
      cyc(1, 0, 0, 16'h0001);
      chk8("pre_clr", 8'h80, 1'b0, 1'b1);
      @(negedge C);
      CE = 1'b1; LOAD = 1'b1; SUB = 1'b0; d8 = 8'h5A; d16 = 16'h005A;
      #2 CLR = 1'b1;
      #1;
      chk8("clr_async", 8'h00, 1'b0, 1'b0);
      check("clr_init_q", q8i, 8'h3C);
      @(posedge C);
      #1;
      chk8("clr_hold", 8'h00, 1'b0, 1'b0);
      check("clr_hold_init_q", q8i, 8'h3C);
      @(negedge C);
      CLR = 1'b0; CE = 1'b0;
      m_q = '0; m_c = 1'b0; m_o = 1'b0;
      cyc(1, 1, 0, 16'h007F);
      cyc(1, 0, 0, 16'h0001);
      chk8("add_ovf", 8'h80, 1'b0, 1'b1);
      cyc(1, 0, 0, 16'h0000);
      chk8("add_zero_sticky", 8'h80, 1'b0, 1'b1);
      cyc(1, 1, 0, 16'h0010);
      chk8("load_clears", 8'h10, 1'b0, 1'b0);
      cyc(1, 1, 0, 16'h00FF);
      cyc(1, 0, 0, 16'h0001);
      chk8("add_wrap", 8'h00, 1'b1, 1'b0);
      cyc(1, 1, 0, 16'h0005);
      cyc(1, 0, 1, 16'h0003);
      chk8("sub_basic", 8'h02, 1'b1, 1'b0);
      cyc(1, 1, 0, 16'h0000);
      cyc(1, 0, 1, 16'h0001);
      chk8("sub_borrow", 8'hFF, 1'b0, 1'b0);
      cyc(1, 1, 0, 16'h0080);
      cyc(1, 0, 1, 16'h0001);
      chk8("sub_ovf", 8'h7F, 1'b1, 1'b1);
      cyc(1, 0, 1, 16'h0000);
      chk8("sub_zero", 8'h7F, 1'b1, 1'b1);
      for (int i = 0; i < 3; i++) begin
         cyc(0, 1, i[0], 16'h00AA);
         chk8("hold", 8'h7F, 1'b1, 1'b1);
      end
      cyc(1, 0, 0, 16'h0001);
      chk8("after_hold", 8'h80, 1'b0, 1'b1);
      cyc(1, 1, 0, 16'h0FFF);
      cyc(1, 0, 0, 16'h0001);
      check("xslice_q16", q16, 16'h1000);
      check("xslice_cout16", c16, 1'b0);
      chk8("xslice_w8", 8'h00, 1'b1, 1'b0);
      for (int i = 0; i < 10000; i++)
         cyc(1, $urandom_range(15) == 0, $urandom_range(1), 16'($urandom));
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
